// File: rtl/gray_rd_arbiter.sv
// gray_rd_arbiter: shares the gray-image memory read port between the LBP window
// fetcher (requester 0) and a secondary reader (requester 1), round-robin with burst lock.
module gray_rd_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        rq_req,
  input  logic [ADDR_W-1:0] rq_addr0,
  input  logic [ADDR_W-1:0] rq_addr1,
  output logic [1:0]        rq_gnt,
  output logic [1:0]        rq_valid,
  output logic [DATA_W-1:0] rq_data,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic              gray_ready,
  input  logic [DATA_W-1:0] gray_data
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_t;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST);

  owner_t      owner_r;
  logic        last_r;
  logic [7:0]  bcnt_r;
  logic [1:0]  vld_r;

  logic        cur_id_s;
  logic        own_req_s;
  logic        other_req_s;
  owner_t      other_owner_s;
  logic        accept_s;
  logic        burst_done_s;

  function automatic logic [1:0] owner_onehot(input owner_t o);
    logic [1:0] oh;
    case (o)
      OWN_R0:  oh = 2'b01;
      OWN_R1:  oh = 2'b10;
      default: oh = 2'b00;
    endcase
    return oh;
  endfunction

  // Memory request mux driven by the current owner, plus accept/grant decode.
  always_comb begin
    cur_id_s      = (owner_r == OWN_R1);
    own_req_s     = cur_id_s ? rq_req[1] : rq_req[0];
    other_req_s   = cur_id_s ? rq_req[0] : rq_req[1];
    other_owner_s = cur_id_s ? OWN_R0 : OWN_R1;
    gray_req      = 1'b0;
    gray_addr     = {ADDR_W{1'b0}};
    case (owner_r)
      OWN_R0: begin
        gray_req  = rq_req[0];
        gray_addr = rq_addr0;
      end
      OWN_R1: begin
        gray_req  = rq_req[1];
        gray_addr = rq_addr1;
      end
      default: begin
        gray_req  = 1'b0;
        gray_addr = {ADDR_W{1'b0}};
      end
    endcase
    accept_s     = gray_req & gray_ready;
    rq_gnt       = {2{accept_s}} & owner_onehot(owner_r);
    burst_done_s = ((bcnt_r + 8'd1) == BURST_LAST);
  end

  // Ownership, burst counting and the one-cycle read-data valid pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r <= OWN_NONE;
      last_r  <= 1'b1;
      bcnt_r  <= 8'd0;
      vld_r   <= 2'b00;
    end else begin
      vld_r <= rq_gnt;
      case (owner_r)
        OWN_NONE: begin
          bcnt_r <= 8'd0;
          case (rq_req)
            2'b01:   owner_r <= OWN_R0;
            2'b10:   owner_r <= OWN_R1;
            2'b11:   owner_r <= last_r ? OWN_R0 : OWN_R1;
            default: owner_r <= OWN_NONE;
          endcase
        end
        OWN_R0, OWN_R1: begin
          if (accept_s) begin
            if (burst_done_s) begin
              // Burst window full: hand over only if the other side is waiting.
              bcnt_r <= 8'd0;
              if (other_req_s) begin
                owner_r <= other_owner_s;
                last_r  <= cur_id_s;
              end
            end else begin
              bcnt_r <= bcnt_r + 8'd1;
            end
          end else if (!own_req_s) begin
            last_r  <= cur_id_s;
            bcnt_r  <= 8'd0;
            owner_r <= other_req_s ? other_owner_s : OWN_NONE;
          end
        end
        default: begin
          owner_r <= OWN_NONE;
          bcnt_r  <= 8'd0;
        end
      endcase
    end
  end

  assign rq_valid = vld_r;
  assign rq_data  = gray_data;

endmodule

// File: tb/tb_gray_rd_arbiter.sv
// Directed self-checking bench for gray_rd_arbiter with a 1-cycle-latency memory model.
module tb_gray_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rq_req;
  logic [13:0] rq_addr0;
  logic [13:0] rq_addr1;
  logic [1:0]  rq_gnt;
  logic [1:0]  rq_valid;
  logic [7:0]  rq_data;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic        gray_ready;
  logic [7:0]  gray_data;

  int n_checks = 0;
  int n_fail   = 0;

  gray_rd_arbiter #(.ADDR_W(14), .DATA_W(8), .MAX_BURST(9)) dut (
    .clk(clk), .reset(reset), .rq_req(rq_req), .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
    .rq_gnt(rq_gnt), .rq_valid(rq_valid), .rq_data(rq_data), .gray_req(gray_req),
    .gray_addr(gray_addr), .gray_ready(gray_ready), .gray_data(gray_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h3C;
  endfunction

  // Memory: returns mem_f(addr) the cycle after an accepted read.
  always @(posedge clk) begin
    if (gray_req && gray_ready) gray_data <= mem_f(gray_addr);
    else gray_data <= 8'hEE;
  end

  task automatic do_reset();
    reset = 1'b1; rq_req = 2'b00; rq_addr0 = 14'd0; rq_addr1 = 14'd0; gray_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rq_req = 2'b11; rq_addr0 = 14'd5; rq_addr1 = 14'd6; gray_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (gray_req !== 1'b0) begin n_fail++; $display("FAIL reset_gray_req got=%b exp=0", gray_req); end
    n_checks++; if (gray_addr !== 14'd0) begin n_fail++; $display("FAIL reset_gray_addr got=%0d exp=0", gray_addr); end
    n_checks++; if (rq_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got=%b exp=00", rq_gnt); end
    n_checks++; if (rq_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid got=%b exp=00", rq_valid); end
  endtask

  task automatic test_single_r0();
    logic [13:0] addrs [3];
    logic [1:0]  eg, ev;
    addrs[0] = 14'd0; addrs[1] = 14'd1; addrs[2] = 14'd129;
    do_reset();
    rq_req = 2'b01; rq_addr0 = addrs[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      eg = (c >= 1 && c <= 3) ? 2'b01 : 2'b00;
      ev = (c >= 2 && c <= 4) ? 2'b01 : 2'b00;
      n_checks++; if (rq_gnt !== eg) begin n_fail++; $display("FAIL single_gnt c=%0d got=%b exp=%b", c, rq_gnt, eg); end
      n_checks++; if (rq_valid !== ev) begin n_fail++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, rq_valid, ev); end
      if (eg != 2'b00) begin
        n_checks++; if (gray_addr !== addrs[c-1]) begin n_fail++; $display("FAIL single_addr c=%0d got=%0d exp=%0d", c, gray_addr, addrs[c-1]); end
      end
      if (ev != 2'b00) begin
        n_checks++; if (rq_data !== mem_f(addrs[c-2])) begin n_fail++; $display("FAIL single_data c=%0d got=%h exp=%h", c, rq_data, mem_f(addrs[c-2])); end
      end
      @(posedge clk); #1;
      if (c == 1 || c == 2) rq_addr0 = addrs[c];
      else if (c == 3) rq_req = 2'b00;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] eg, prev;
    int n0, n1;
    n0 = 0; n1 = 0; prev = 2'b00;
    do_reset();
    rq_req = 2'b11; rq_addr0 = 14'd100; rq_addr1 = 14'd200;
    for (int c = 0; c < 29; c++) begin
      @(negedge clk);
      if (c == 0) eg = 2'b00;
      else eg = ((((c - 1) / 9) % 2) == 0) ? 2'b01 : 2'b10;
      n_checks++; if (rq_gnt !== eg) begin n_fail++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, rq_gnt, eg); end
      n_checks++; if (rq_valid !== prev) begin n_fail++; $display("FAIL rr_valid c=%0d got=%b exp=%b", c, rq_valid, prev); end
      if (eg == 2'b01) begin
        n_checks++; if (gray_addr !== 14'(100 + n0)) begin n_fail++; $display("FAIL rr_addr0 c=%0d got=%0d exp=%0d", c, gray_addr, 100 + n0); end
        n0++;
      end else if (eg == 2'b10) begin
        n_checks++; if (gray_addr !== 14'(200 + n1)) begin n_fail++; $display("FAIL rr_addr1 c=%0d got=%0d exp=%0d", c, gray_addr, 200 + n1); end
        n1++;
      end
      prev = eg;
      @(posedge clk); #1;
      rq_addr0 = 14'(100 + n0); rq_addr1 = 14'(200 + n1);
    end
    rq_req = 2'b00;
  endtask

  task automatic test_long_burst();
    logic [1:0] eg, ev;
    do_reset();
    rq_req = 2'b01; rq_addr0 = 14'd1000;
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      eg = (c >= 1 && c <= 20) ? 2'b01 : 2'b00;
      ev = (c >= 2 && c <= 21) ? 2'b01 : 2'b00;
      n_checks++; if (rq_gnt !== eg) begin n_fail++; $display("FAIL long_gnt c=%0d got=%b exp=%b", c, rq_gnt, eg); end
      n_checks++; if (rq_valid !== ev) begin n_fail++; $display("FAIL long_valid c=%0d got=%b exp=%b", c, rq_valid, ev); end
      if (ev != 2'b00) begin
        n_checks++; if (rq_data !== mem_f(14'(1000 + c - 2))) begin n_fail++; $display("FAIL long_data c=%0d got=%h exp=%h", c, rq_data, mem_f(14'(1000 + c - 2))); end
      end
      @(posedge clk); #1;
      if (c == 20) rq_req = 2'b00;
      else if (c >= 1) rq_addr0 = 14'(1000 + c);
    end
  endtask

  task automatic test_stall();
    logic [1:0] eg;
    int n1;
    n1 = 0;
    do_reset();
    rq_req = 2'b10; rq_addr1 = 14'd300; rq_addr0 = 14'd50;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 0 || (c >= 5 && c <= 7)) eg = 2'b00;
      else if (c <= 12) eg = 2'b10;
      else eg = 2'b01;
      n_checks++; if (rq_gnt !== eg) begin n_fail++; $display("FAIL stall_gnt c=%0d got=%b exp=%b", c, rq_gnt, eg); end
      if (c >= 5 && c <= 7) begin
        n_checks++; if (gray_req !== 1'b1 || gray_addr !== 14'd304) begin n_fail++; $display("FAIL stall_hold c=%0d got req=%b addr=%0d exp req=1 addr=304", c, gray_req, gray_addr); end
      end
      if (eg == 2'b10) begin
        n_checks++; if (gray_addr !== 14'(300 + n1)) begin n_fail++; $display("FAIL stall_addr c=%0d got=%0d exp=%0d", c, gray_addr, 300 + n1); end
        n1++;
      end
      @(posedge clk); #1;
      if (c == 0) rq_req = 2'b11;
      rq_addr1 = 14'(300 + n1);
      gray_ready = !((c + 1) >= 5 && (c + 1) <= 7);
    end
    n_checks++; if (n1 !== 9) begin n_fail++; $display("FAIL stall_total got=%0d exp=9", n1); end
    rq_req = 2'b00; gray_ready = 1'b1;
  endtask

  task automatic test_drop();
    logic [1:0]  eg_t [8];
    logic [1:0]  ev_t [8];
    logic [13:0] last_addr;
    eg_t = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    ev_t = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
    last_addr = 14'd0;
    do_reset();
    rq_req = 2'b11; rq_addr0 = 14'd400; rq_addr1 = 14'd500;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++; if (rq_gnt !== eg_t[c]) begin n_fail++; $display("FAIL drop_gnt c=%0d got=%b exp=%b", c, rq_gnt, eg_t[c]); end
      n_checks++; if (rq_valid !== ev_t[c]) begin n_fail++; $display("FAIL drop_valid c=%0d got=%b exp=%b", c, rq_valid, ev_t[c]); end
      if (ev_t[c] != 2'b00) begin
        n_checks++; if (rq_data !== mem_f(last_addr)) begin n_fail++; $display("FAIL drop_data c=%0d got=%h exp=%h", c, rq_data, mem_f(last_addr)); end
      end
      if (eg_t[c] == 2'b01) last_addr = 14'(400 + c - 1);
      else if (eg_t[c] == 2'b10) last_addr = 14'(500 + c - 6);
      @(posedge clk); #1;
      if (c >= 1 && c <= 3) rq_addr0 = 14'(400 + c);
      if (c == 4) rq_req = 2'b10;
      if (c >= 6) rq_addr1 = 14'(500 + c - 5);
    end
    rq_req = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rq_req = 2'b11; rq_addr0 = 14'd600; rq_addr1 = 14'd700;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (rq_valid !== 2'b00) begin n_fail++; $display("FAIL mid_valid got=%b exp=00", rq_valid); end
    n_checks++; if (gray_req !== 1'b0) begin n_fail++; $display("FAIL mid_gray_req got=%b exp=0", gray_req); end
    n_checks++; if (rq_gnt !== 2'b00) begin n_fail++; $display("FAIL mid_gnt got=%b exp=00", rq_gnt); end
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (rq_gnt !== ((c >= 1) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL mid_after_gnt c=%0d got=%b", c, rq_gnt); end
      n_checks++; if (rq_valid !== ((c == 2) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL mid_after_valid c=%0d got=%b", c, rq_valid); end
      @(posedge clk); #1;
    end
    rq_req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_r0();
    test_round_robin();
    test_long_burst();
    test_stall();
    test_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_rd_arbiter.md
Name: gray_rd_arbiter

Overview:
- Shares the single gray-image memory read port between two read requesters.
- Requester 0 is the LBP window fetcher. Requester 1 is a secondary reader, such as a host readback or statistics unit.
- Arbitration is round-robin with a bounded burst lock, so one 3x3 window fetch (9 reads) can complete without interleaving.
- Sits between the requesters and the gray memory; it does no data processing.

Parameters:
- ADDR_W, 14, width of gray memory address.
- DATA_W, 8, width of gray pixel data.
- MAX_BURST, 9, number of accepted reads an owner may issue before it must yield to a pending other requester; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rq_req  in  2  per-requester read request; bit i belongs to requester i.
- rq_addr0  in  ADDR_W  requester 0 read address.
- rq_addr1  in  ADDR_W  requester 1 read address.
- rq_gnt  out  2  per-requester accept strobe; combinational; high in the cycle its address is accepted by memory.
- rq_valid  out  2  per-requester read-data valid; registered.
- rq_data  out  DATA_W  read data; passthrough of gray_data; meaningful only when a rq_valid bit is high.
- gray_req  out  1  memory read request.
- gray_addr  out  ADDR_W  memory read address.
- gray_ready  in  1  memory can accept a read this cycle.
- gray_data  in  DATA_W  memory read data, valid the cycle after acceptance.

Behaviour:
- Memory protocol:
  - A read is accepted on a rising edge where gray_req and gray_ready are both high.
  - gray_data holds that read's data during the following cycle (fixed 1-cycle latency).
- State registers:
  - owner: NONE, R0 or R1.
  - last: id of the last owner.
  - bcnt: accepted-read count of the current owner, width 8.
  - vld_q: 2 bits.
- Reset values: owner=NONE, last=1 (requester 0 wins the first tie), bcnt=0, vld_q=0.
  - Resulting outputs: gray_req=0, gray_addr=0, rq_gnt=0, rq_valid=0.
- Datapath while owner=Ri (combinational): gray_req = rq_req[i]; gray_addr = rq_addr_i; rq_gnt[i] = gray_req & gray_ready.
- Datapath while owner=NONE: gray_req=0, gray_addr=0, rq_gnt=0.
- Read-data return: rq_valid <= {2{accept}} & onehot(owner) each cycle, giving 1-cycle valid latency after rq_gnt. rq_data = gray_data.
- Transitions from NONE:
  - Exactly one rq_req bit high: owner <= that requester.
  - Both high: owner <= ~last.
  - Neither high: stay NONE.
  - bcnt <= 0 in all cases.
  - This costs one idle arbitration cycle, with no memory request in that cycle.
- Transitions from Ri, evaluated in priority order:
  1. Accept and bcnt+1 == MAX_BURST and other requester's rq_req high: owner <= other, last <= i, bcnt <= 0. No idle cycle between owners.
  2. Accept and bcnt+1 == MAX_BURST and other not requesting: stay Ri, bcnt <= 0, starting a new burst window.
  3. Accept otherwise: bcnt <= bcnt+1.
  4. rq_req[i] low: last <= i, bcnt <= 0. owner <= other if other requesting, else NONE.
  5. rq_req[i] high but gray_ready low: hold owner and bcnt (stall).
- Requester rules:
  - A requester must hold rq_req and rq_addr stable until it sees rq_gnt.
  - It may change the address in the cycle after rq_gnt.
  - It may deassert rq_req at any time it has no unaccepted request.
- Owner change never drops in-flight data: a read accepted on the switching edge still raises the old owner's rq_valid in the next cycle.
- Reset asserted mid-operation: all state cleared immediately. Any read in flight is discarded and its rq_valid is never raised.
- At most one rq_gnt bit and one rq_valid bit is high per cycle.

Test Plan:
- Single requester 0 reads addresses 0,1,129 with gray_ready=1 → gnt0 in 3 consecutive cycles after 1 idle cycle; rq_valid[0] one cycle after each gnt, rq_data = memory contents.
- Both requesters continuously requesting, MAX_BURST=9, ready=1 → 9 gnt0, then 9 gnt1, then 9 gnt0; no idle cycle at switches; no gnt1 during requester 0's burst.
- Requester 0 alone holds req for 20 reads → 20 consecutive gnt0 with no idle or bubble (burst counter wraps at 9 and 18).
- gray_ready low for 3 cycles in the middle of a requester-1 burst → gray_addr held stable, no gnt, bcnt frozen; burst resumes and completes 9 accepts total.
- Requester 0 drops req after 4 reads while requester 1 waits → owner moves to R1 on the next edge; the 4th read's rq_valid[0] still asserts.
- Assert reset while a read is in flight → rq_valid=0 and gray_req=0 immediately. After release with both requesting, requester 0 is granted first.
